// File: rtl/hazard_scoreboard_unit_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard/scoreboard unit (slave).
interface HazardScoreboardIf #(
  parameter int AW   = 5,
  parameter int NSRC = 3
);
  logic                 mem_stall;
  logic                 pc_selE;
  logic [NSRC*AW-1:0]   rsD;
  logic [NSRC-1:0]      rs_selD;
  logic [NSRC-1:0]      rs_vldD;
  logic [AW-1:0]        rdD;
  logic                 rdW_selD;
  logic                 reg_writeD;
  logic                 fdiv_startD;
  logic [NSRC*AW-1:0]   rsE;
  logic [NSRC-1:0]      rs_selE;
  logic [AW-1:0]        rdE;
  logic                 rdW_selE;
  logic                 result_selE;
  logic                 fdiv_startE;
  logic [AW-1:0]        rdM;
  logic                 rdW_selM;
  logic                 reg_writeM;
  logic [AW-1:0]        rdW;
  logic                 rdW_selW;
  logic                 reg_writeW;
  logic [NSRC*2-1:0]    forwardE;
  logic                 stallF, stallD, stallE, stallM, stallW;
  logic                 flushD, flushE;
  logic                 fdiv_busy;
  logic                 fdiv_wb;
  logic [AW-1:0]        fdiv_rd;
  logic [31:0]          lu_stall_cnt;
  logic [31:0]          div_stall_cnt;

  modport master (
    output mem_stall, pc_selE, rsD, rs_selD, rs_vldD, rdD, rdW_selD, reg_writeD, fdiv_startD,
           rsE, rs_selE, rdE, rdW_selE, result_selE, fdiv_startE,
           rdM, rdW_selM, reg_writeM, rdW, rdW_selW, reg_writeW,
    input  forwardE, stallF, stallD, stallE, stallM, stallW, flushD, flushE,
           fdiv_busy, fdiv_wb, fdiv_rd, lu_stall_cnt, div_stall_cnt
  );

  modport slave (
    input  mem_stall, pc_selE, rsD, rs_selD, rs_vldD, rdD, rdW_selD, reg_writeD, fdiv_startD,
           rsE, rs_selE, rdE, rdW_selE, result_selE, fdiv_startE,
           rdM, rdW_selM, reg_writeM, rdW, rdW_selW, reg_writeW,
    output forwardE, stallF, stallD, stallE, stallM, stallW, flushD, flushE,
           fdiv_busy, fdiv_wb, fdiv_rd, lu_stall_cnt, div_stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit: int/fp operand forwarding, load-use/control stalls and a scoreboard for one FP divide/sqrt.
// Define HZ_PERF_CNT_EN to build the load-use and divide stall performance counters.
module hazard_scoreboard_unit #(
  parameter int AW       = 5,
  parameter int NSRC     = 3,
  parameter int FDIV_LAT = 12,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              rst_n,
  HazardScoreboardIf.slave hz
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_e;

  divState_e        divState;
  logic [CNT_W-1:0] divCnt;
  logic [AW-1:0]    fdivRd;
  logic             fdivBusy;
  logic             fdivWb;
  logic             luHazard;
  logic             sbHazard;

  // Integer x0 is hardwired zero and never creates a dependency; fp f0 is a real register.
  function automatic logic sameReg(input logic [AW-1:0] rs, input logic rsFp,
                                   input logic [AW-1:0] rd, input logic rdFp);
    return (rs == rd) && (rsFp == rdFp) && (rsFp || (rs != '0));
  endfunction

  always_comb begin
    hz.forwardE = '0;
    if (rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        if (hz.reg_writeM && sameReg(hz.rsE[i*AW +: AW], hz.rs_selE[i], hz.rdM, hz.rdW_selM))
          hz.forwardE[2*i +: 2] = 2'b10;
        else if (hz.reg_writeW && sameReg(hz.rsE[i*AW +: AW], hz.rs_selE[i], hz.rdW, hz.rdW_selW))
          hz.forwardE[2*i +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    luHazard = 1'b0;
    sbHazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz.result_selE && hz.rs_vldD[i] &&
          sameReg(hz.rsD[i*AW +: AW], hz.rs_selD[i], hz.rdE, hz.rdW_selE))
        luHazard = 1'b1;
      if (fdivBusy && hz.rs_vldD[i] && hz.rs_selD[i] && (hz.rsD[i*AW +: AW] == fdivRd))
        sbHazard = 1'b1;
    end
    if (fdivBusy && (hz.fdiv_startD || (hz.reg_writeD && hz.rdW_selD && (hz.rdD == fdivRd))))
      sbHazard = 1'b1;
  end

  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.stallW = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    if (!rst_n) begin
      hz.stallF = 1'b0;
    end else if (hz.mem_stall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
      hz.stallW = 1'b1;
    end else if (hz.pc_selE) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
    end else if (luHazard || sbHazard) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

  // Counter starts at FDIV_LAT-2 so BUSY plus the single DONE cycle span exactly FDIV_LAT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divState <= IDLE;
      divCnt   <= '0;
      fdivRd   <= '0;
      fdivBusy <= 1'b0;
      fdivWb   <= 1'b0;
    end else if (!hz.mem_stall) begin
      unique case (divState)
        IDLE: begin
          if (hz.fdiv_startE) begin
            divState <= BUSY;
            divCnt   <= CNT_W'(FDIV_LAT - 2);
            fdivRd   <= hz.rdE;
            fdivBusy <= 1'b1;
          end
        end
        BUSY: begin
          if (divCnt == '0) begin
            divState <= DONE;
            fdivWb   <= 1'b1;
          end else begin
            divCnt <= divCnt - 1'b1;
          end
        end
        DONE: begin
          divState <= IDLE;
          fdivBusy <= 1'b0;
          fdivWb   <= 1'b0;
        end
        default: begin
          divState <= IDLE;
          fdivBusy <= 1'b0;
          fdivWb   <= 1'b0;
        end
      endcase
    end
  end

  assign hz.fdiv_busy = fdivBusy;
  assign hz.fdiv_wb   = fdivWb;
  assign hz.fdiv_rd   = fdivRd;

`ifdef HZ_PERF_CNT_EN
  logic [31:0] luStallCnt;
  logic [31:0] divStallCnt;

  // Only cycles where the D-stage hold actually wins (no memory stall, no redirect) are counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luStallCnt  <= '0;
      divStallCnt <= '0;
    end else if (!hz.mem_stall && !hz.pc_selE) begin
      if (luHazard) luStallCnt  <= luStallCnt + 32'd1;
      if (sbHazard) divStallCnt <= divStallCnt + 32'd1;
    end
  end

  assign hz.lu_stall_cnt  = luStallCnt;
  assign hz.div_stall_cnt = divStallCnt;
`else
  assign hz.lu_stall_cnt  = '0;
  assign hz.div_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: cycle-level model compare plus directed literal checks.
// Honours HZ_PERF_CNT_EN the same way as the design build.
module tb_hazard_scoreboard_unit;
  localparam int AW       = 5;
  localparam int NSRC     = 3;
  localparam int FDIV_LAT = 12;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;

  int          divRem;
  logic [AW-1:0] divRd;
  logic [31:0] luModel;
  logic [31:0] divModel;

  HazardScoreboardIf #(.AW(AW), .NSRC(NSRC)) hzIf ();

  hazard_scoreboard_unit #(.AW(AW), .NSRC(NSRC), .FDIV_LAT(FDIV_LAT), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hzIf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    hzIf.mem_stall   = 1'b0; hzIf.pc_selE     = 1'b0;
    hzIf.rsD         = '0;   hzIf.rs_selD     = '0;   hzIf.rs_vldD    = '0;
    hzIf.rdD         = '0;   hzIf.rdW_selD    = 1'b0; hzIf.reg_writeD = 1'b0;
    hzIf.fdiv_startD = 1'b0;
    hzIf.rsE         = '0;   hzIf.rs_selE     = '0;
    hzIf.rdE         = '0;   hzIf.rdW_selE    = 1'b0;
    hzIf.result_selE = 1'b0; hzIf.fdiv_startE = 1'b0;
    hzIf.rdM         = '0;   hzIf.rdW_selM    = 1'b0; hzIf.reg_writeM = 1'b0;
    hzIf.rdW         = '0;   hzIf.rdW_selW    = 1'b0; hzIf.reg_writeW = 1'b0;
  endtask

  function automatic bit sameReg(input logic [AW-1:0] a, input logic aFp, input logic [AW-1:0] b, input logic bFp);
    return (a == b) && (aFp == bFp) && (aFp || a != 0);
  endfunction

  function automatic logic [2*NSRC-1:0] modelFwd();
    logic [2*NSRC-1:0] f;
    f = '0;
    if (!rst_n) return f;
    for (int i = 0; i < NSRC; i++) begin
      if (hzIf.reg_writeM && sameReg(hzIf.rsE[i*AW +: AW], hzIf.rs_selE[i], hzIf.rdM, hzIf.rdW_selM))
        f[2*i +: 2] = 2'b10;
      else if (hzIf.reg_writeW && sameReg(hzIf.rsE[i*AW +: AW], hzIf.rs_selE[i], hzIf.rdW, hzIf.rdW_selW))
        f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic bit modelLu();
    if (!hzIf.result_selE) return 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (hzIf.rs_vldD[i] && sameReg(hzIf.rsD[i*AW +: AW], hzIf.rs_selD[i], hzIf.rdE, hzIf.rdW_selE))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit modelSb();
    if (divRem == 0) return 1'b0;
    if (hzIf.fdiv_startD) return 1'b1;
    if (hzIf.reg_writeD && hzIf.rdW_selD && hzIf.rdD == divRd) return 1'b1;
    for (int i = 0; i < NSRC; i++)
      if (hzIf.rs_vldD[i] && hzIf.rs_selD[i] && hzIf.rsD[i*AW +: AW] == divRd)
        return 1'b1;
    return 1'b0;
  endfunction

  // Order: stallF stallD stallE stallM stallW flushD flushE
  function automatic logic [6:0] modelCtl();
    if (!rst_n)                 return 7'b00000_00;
    if (hzIf.mem_stall)         return 7'b11111_00;
    if (hzIf.pc_selE)           return 7'b00000_11;
    if (modelLu() || modelSb()) return 7'b11000_01;
    return 7'b00000_00;
  endfunction

  // divRem = frozen-aware cycles left until the writeback cycle (1 means writeback now).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divRem   <= 0;
      divRd    <= '0;
      luModel  <= '0;
      divModel <= '0;
    end else if (!hzIf.mem_stall) begin
      if (divRem > 0) divRem <= divRem - 1;
      else if (hzIf.fdiv_startE) begin
        divRem <= FDIV_LAT;
        divRd  <= hzIf.rdE;
      end
      if (!hzIf.pc_selE) begin
        if (modelLu()) luModel  <= luModel + 32'd1;
        if (modelSb()) divModel <= divModel + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("modelFwd", hzIf.forwardE, modelFwd());
    checkOutput("modelCtl", {hzIf.stallF, hzIf.stallD, hzIf.stallE, hzIf.stallM, hzIf.stallW,
                             hzIf.flushD, hzIf.flushE}, modelCtl());
    checkOutput("modelBusy", hzIf.fdiv_busy, rst_n && divRem > 0);
    checkOutput("modelWb", hzIf.fdiv_wb, rst_n && divRem == 1);
    checkOutput("modelRd", hzIf.fdiv_rd, divRd);
`ifdef HZ_PERF_CNT_EN
    checkOutput("modelLuCnt", hzIf.lu_stall_cnt, luModel);
    checkOutput("modelDivCnt", hzIf.div_stall_cnt, divModel);
`else
    checkOutput("modelLuCnt", hzIf.lu_stall_cnt, 64'd0);
    checkOutput("modelDivCnt", hzIf.div_stall_cnt, 64'd0);
`endif
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rstBusy", hzIf.fdiv_busy, 64'd0);
    checkOutput("rstRd", hzIf.fdiv_rd, 64'd0);
    applyStimulus();
    rst_n = 1'b1;

    // Forwarding: x5 from M, then W, x0 never, fp f0 does, M beats W
    hzIf.rdM = 5'd5; hzIf.reg_writeM = 1'b1;
    hzIf.rsE[0*AW +: AW] = 5'd5; hzIf.rsE[1*AW +: AW] = 5'd5;
    @(negedge clk);
    checkOutput("fwdM", hzIf.forwardE, 64'b00_10_10);
    applyStimulus();
    hzIf.reg_writeM = 1'b0; hzIf.rdW = 5'd5; hzIf.reg_writeW = 1'b1;
    @(negedge clk);
    checkOutput("fwdW", hzIf.forwardE, 64'b00_01_01);
    applyStimulus();
    hzIf.rdM = 5'd5; hzIf.reg_writeM = 1'b1;
    @(negedge clk);
    checkOutput("fwdPrio", hzIf.forwardE, 64'b00_10_10);
    applyStimulus();
    hzIf.rdM = 5'd0; hzIf.rdW = 5'd0; hzIf.rsE = '0;
    @(negedge clk);
    checkOutput("fwdX0", hzIf.forwardE, 64'b00_00_00);
    applyStimulus();
    hzIf.rdW_selM = 1'b1; hzIf.rs_selE = 3'b001;
    @(negedge clk);
    checkOutput("fwdF0", hzIf.forwardE, 64'b00_00_10);
    applyStimulus();
    idleInputs();

    // Load-use on x7; fp f7 read and int x0 do not stall
    hzIf.result_selE = 1'b1; hzIf.rdE = 5'd7;
    hzIf.rsD[0*AW +: AW] = 5'd7; hzIf.rs_vldD = 3'b001;
    @(negedge clk);
    checkOutput("luStall", {hzIf.stallF, hzIf.stallD, hzIf.flushE, hzIf.flushD}, 64'b1110);
    applyStimulus();
    hzIf.rs_selD = 3'b001;
    @(negedge clk);
    checkOutput("luFpNoStall", {hzIf.stallF, hzIf.stallD, hzIf.flushE}, 64'b000);
    applyStimulus();
    hzIf.rs_selD = '0; hzIf.rdE = 5'd0; hzIf.rsD = '0;
    @(negedge clk);
    checkOutput("luX0NoStall", hzIf.stallD, 64'd0);
    applyStimulus();
    idleInputs();

    // fdiv f3, fmadd reads f3 as rs3 until writeback
    hzIf.fdiv_startE = 1'b1; hzIf.rdE = 5'd3; hzIf.rdW_selE = 1'b1;
    @(negedge clk);
    checkOutput("divPreBusy", hzIf.fdiv_busy, 64'd0);
    applyStimulus();
    hzIf.fdiv_startE = 1'b0;
    hzIf.rsD[2*AW +: AW] = 5'd3; hzIf.rs_selD = 3'b100; hzIf.rs_vldD = 3'b100;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checkOutput($sformatf("divBusy%0d", k), hzIf.fdiv_busy, (k <= 12) ? 64'd1 : 64'd0);
      checkOutput($sformatf("divWb%0d", k), hzIf.fdiv_wb, (k == 12) ? 64'd1 : 64'd0);
      checkOutput($sformatf("divRaw%0d", k), hzIf.stallD, (k <= 12) ? 64'd1 : 64'd0);
      applyStimulus();
    end
    checkOutput("divRd", hzIf.fdiv_rd, 64'd3);
    idleInputs();

    // Structural and WAW stalls while busy
    hzIf.fdiv_startE = 1'b1; hzIf.rdE = 5'd3; hzIf.rdW_selE = 1'b1;
    applyStimulus();
    hzIf.fdiv_startE = 1'b0;
    hzIf.fdiv_startD = 1'b1;
    @(negedge clk);
    checkOutput("sbStruct", hzIf.stallF, 64'd1);
    applyStimulus();
    hzIf.fdiv_startD = 1'b0; hzIf.reg_writeD = 1'b1; hzIf.rdW_selD = 1'b1; hzIf.rdD = 5'd3;
    @(negedge clk);
    checkOutput("sbWaw", hzIf.stallD, 64'd1);
    applyStimulus();
    hzIf.rdD = 5'd4;
    @(negedge clk);
    checkOutput("sbOtherFp", hzIf.stallD, 64'd0);
    applyStimulus();
    hzIf.rdD = 5'd3; hzIf.rdW_selD = 1'b0;
    @(negedge clk);
    checkOutput("sbIntDest", hzIf.stallD, 64'd0);
    repeat (12) applyStimulus();
    idleInputs();

    // mem_stall for 3 cycles mid-BUSY delays writeback by 3
    hzIf.fdiv_startE = 1'b1; hzIf.rdE = 5'd9; hzIf.rdW_selE = 1'b1;
    applyStimulus();
    hzIf.fdiv_startE = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      hzIf.mem_stall = (k >= 5 && k <= 7);
      @(negedge clk);
      checkOutput($sformatf("msWb%0d", k), hzIf.fdiv_wb, (k == 15) ? 64'd1 : 64'd0);
      if (k == 6)
        checkOutput("msCtl", {hzIf.stallF, hzIf.stallD, hzIf.stallE, hzIf.stallM, hzIf.stallW,
                              hzIf.flushD, hzIf.flushE}, 64'b1111100);
      applyStimulus();
    end
    hzIf.mem_stall = 1'b0;

    // mem_stall in the writeback cycle holds the strobe high
    hzIf.fdiv_startE = 1'b1; hzIf.rdE = 5'd10; hzIf.rdW_selE = 1'b1;
    applyStimulus();
    hzIf.fdiv_startE = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      hzIf.mem_stall = (k == 12 || k == 13);
      @(negedge clk);
      checkOutput($sformatf("msDoneWb%0d", k), hzIf.fdiv_wb, (k >= 12 && k <= 14) ? 64'd1 : 64'd0);
      applyStimulus();
    end
    idleInputs();

    // Redirect beats load-use
    hzIf.pc_selE = 1'b1; hzIf.result_selE = 1'b1; hzIf.rdE = 5'd7;
    hzIf.rsD[0*AW +: AW] = 5'd7; hzIf.rs_vldD = 3'b001;
    @(negedge clk);
    checkOutput("pcSel", {hzIf.stallF, hzIf.stallD, hzIf.flushD, hzIf.flushE}, 64'b0011);
    applyStimulus();
    idleInputs();

    // Reset at cnt=5 aborts the divide
    hzIf.fdiv_startE = 1'b1; hzIf.rdE = 5'd3; hzIf.rdW_selE = 1'b1;
    applyStimulus();
    hzIf.fdiv_startE = 1'b0;
    repeat (5) applyStimulus();
    rst_n = 1'b0;
    hzIf.rdM = 5'd5; hzIf.reg_writeM = 1'b1; hzIf.rsE[0*AW +: AW] = 5'd5; hzIf.mem_stall = 1'b1;
    @(negedge clk);
    checkOutput("rstMidOut", {hzIf.forwardE, hzIf.stallF, hzIf.stallE, hzIf.fdiv_busy, hzIf.fdiv_wb}, 64'd0);
    applyStimulus();
    idleInputs();
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstNoWb%0d", k), hzIf.fdiv_wb, 64'd0);
      applyStimulus();
    end

    // Two load-use stall cycles
    hzIf.result_selE = 1'b1; hzIf.rdE = 5'd7;
    hzIf.rsD[1*AW +: AW] = 5'd7; hzIf.rs_vldD = 3'b010;
    repeat (2) applyStimulus();
    idleInputs();
    @(negedge clk);
`ifdef HZ_PERF_CNT_EN
    checkOutput("perfLu", hzIf.lu_stall_cnt, 64'd2);
`else
    checkOutput("perfLu", hzIf.lu_stall_cnt, 64'd0);
`endif
    checkOutput("perfDiv", hzIf.div_stall_cnt, 64'd0);
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
